// File: rtl/voice_frame_sequencer_if.sv
// Voice engine scheduling bus: rate/enable control in, per-voice start/done
// handshake with the shared datapath, and frame status out.
interface voice_frame_sequencer_if #(
    parameter int VW = 3,
    parameter int CW = 10
);
    logic          enable;
    logic          rate;
    logic          voice_done;
    logic          clear_err;
    logic          voice_start;
    logic [VW-1:0] voice_sel;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] cycles_used;
    logic          overrun;
    logic          err_timeout;

    // Sequencer side: drives the datapath strobes and status
    modport master (
        input  enable, rate, voice_done, clear_err,
        output voice_start, voice_sel, busy, frame_done, cycles_used,
               overrun, err_timeout
    );

    // Environment side: clock generator, voice datapath and control
    modport slave (
        output enable, rate, voice_done, clear_err,
        input  voice_start, voice_sel, busy, frame_done, cycles_used,
               overrun, err_timeout
    );
endinterface

// File: rtl/voice_frame_sequencer.sv
// Per-sample scheduler for the time-shared voice DSP engine. Each accepted
// rate pulse starts a frame that issues voices 0..NVOICES-1 in order, waiting
// for each voice's done (or a timeout) before issuing the next one.
module voice_frame_sequencer #(
    parameter int NVOICES = 8,
    parameter int VW      = 3,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7,
    parameter int CW      = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    voice_frame_sequencer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [VW-1:0] LAST_V = VW'(NVOICES - 1);
    localparam logic [TW-1:0] LAST_W = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] C_MAX  = '1;

    state_t        state;
    logic [VW-1:0] vidx;
    logic [TW-1:0] wcnt;
    logic [CW-1:0] ccnt;
    logic [CW-1:0] ccnt_inc;
    logic          tmo_hit;
    logic          advance;

    // Frame length counter saturates rather than wrapping
    assign ccnt_inc = (ccnt == C_MAX) ? ccnt : ccnt + 1'b1;
    // Voice finished this cycle, either by handshake or by forced advance
    assign tmo_hit  = (state == WAIT) && !bus.voice_done && (wcnt == LAST_W);
    assign advance  = bus.voice_done || (wcnt == LAST_W);

    // Frame FSM with registered outputs and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            vidx            <= '0;
            wcnt            <= '0;
            ccnt            <= '0;
            bus.voice_start <= 1'b0;
            bus.voice_sel   <= '0;
            bus.busy        <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.cycles_used <= '0;
            bus.overrun     <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.voice_start <= 1'b0;
            bus.frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rate && bus.enable) begin
                        state           <= ISSUE;
                        vidx            <= '0;
                        ccnt            <= '0;
                        bus.voice_start <= 1'b1;
                        bus.voice_sel   <= '0;
                        bus.busy        <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    wcnt  <= '0;
                    ccnt  <= ccnt_inc;
                end
                WAIT: begin
                    ccnt <= ccnt_inc;
                    if (advance) begin
                        if (vidx == LAST_V) begin
                            // cycles_used is valid in the same cycle as frame_done
                            state           <= DONE;
                            bus.frame_done  <= 1'b1;
                            bus.cycles_used <= ccnt_inc;
                        end else begin
                            state           <= ISSUE;
                            vidx            <= vidx + 1'b1;
                            bus.voice_sel   <= vidx + 1'b1;
                            bus.voice_start <= 1'b1;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // New errors take priority over a same-cycle clear
            bus.overrun     <= (bus.overrun && !bus.clear_err) ||
                               (bus.rate && (state != IDLE));
            bus.err_timeout <= (bus.err_timeout && !bus.clear_err) || tmo_hit;
        end
    end
endmodule

// File: tb/tb_voice_frame_sequencer.sv
// Bench for voice_frame_sequencer: each frame's schedule (start cycles,
// frame_done cycle, length, error flags) is derived arithmetically from the
// per-voice done delays, then the outputs are compared every cycle.
module tb_voice_frame_sequencer;
    localparam int NV = 8;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset;

    voice_frame_sequencer_if #(.VW(3), .CW(10)) bus ();

    voice_frame_sequencer #(
        .NVOICES(NV), .VW(3), .TIMEOUT(TO), .TW(7), .CW(10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-voice done delay after its start; 0 means the engine never answers
    int dly [NV];
    int s   [NV];
    int fd;

    logic exp_ovr, exp_tmo;
    int   exp_sel, exp_cu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Frame schedule: voice i starts at s[i], waits min(delay, TO) cycles
    function automatic void plan();
        int w;
        s[0] = 1;
        for (int i = 0; i < NV; i++) begin
            w = (dly[i] == 0) ? TO : dly[i];
            if (i < NV - 1) s[i+1] = s[i] + 1 + w;
            else            fd     = s[i] + 1 + w;
        end
    endfunction

    task automatic check_cycle(input logic st, input logic fdn, input logic bsy, input string tg);
        @(negedge clk);
        chk({tg, " voice_start"}, 32'(bus.voice_start), 32'(st));
        chk({tg, " frame_done"},  32'(bus.frame_done),  32'(fdn));
        chk({tg, " busy"},        32'(bus.busy),        32'(bsy));
        chk({tg, " voice_sel"},   32'(bus.voice_sel),   32'(exp_sel));
        chk({tg, " cycles_used"}, 32'(bus.cycles_used), 32'(exp_cu));
        chk({tg, " overrun"},     32'(bus.overrun),     32'(exp_ovr));
        chk({tg, " err_timeout"}, 32'(bus.err_timeout), 32'(exp_tmo));
    endtask

    // One frame from a rate pulse at relative cycle 0 through one idle cycle
    task automatic run_frame(input string tg, input int ovr_at, input int clr_at, input bit en_drop);
        logic st, vd, forced;
        plan();
        if (ovr_at == -2) ovr_at = fd;
        for (int c = 0; c <= fd + 1; c++) begin
            st = 1'b0; vd = 1'b0; forced = 1'b0;
            for (int i = 0; i < NV; i++) begin
                if (c == s[i]) begin st = 1'b1; exp_sel = i; end
                if (dly[i] != 0 && c == s[i] + dly[i]) vd = 1'b1;
                if (dly[i] == 0 && c == s[i] + TO) forced = 1'b1;
            end
            bus.rate       = (c == 0) || (c == ovr_at);
            bus.enable     = en_drop ? (c == 0) : 1'b1;
            bus.voice_done = vd;
            bus.clear_err  = (c == clr_at);
            if (c == fd) exp_cu = fd - 1;
            check_cycle(st, c == fd, (c >= 1) && (c <= fd), tg);
            exp_ovr = (exp_ovr && !(c == clr_at)) || (bus.rate && c >= 1 && c <= fd);
            exp_tmo = (exp_tmo && !(c == clr_at)) || forced;
            next_cycle();
        end
        bus.rate = 1'b0; bus.voice_done = 1'b0; bus.clear_err = 1'b0; bus.enable = 1'b1;
    endtask

    // Cycles with no frame running; rate&enable together must not be requested
    task automatic idle(input string tg, input int n, input logic r, input logic en,
                        input logic vd, input logic clr);
        for (int k = 0; k < n; k++) begin
            bus.rate = r; bus.enable = en; bus.voice_done = vd; bus.clear_err = clr;
            check_cycle(1'b0, 1'b0, 1'b0, tg);
            exp_ovr = exp_ovr && !clr;
            exp_tmo = exp_tmo && !clr;
            next_cycle();
        end
        bus.rate = 1'b0; bus.enable = 1'b1; bus.voice_done = 1'b0; bus.clear_err = 1'b0;
    endtask

    task automatic set_all(input int d);
        for (int i = 0; i < NV; i++) dly[i] = d;
    endtask

    initial begin
        int ovr, clr;
        bus.rate = 1'b0; bus.enable = 1'b0; bus.voice_done = 1'b0; bus.clear_err = 1'b0;
        exp_ovr = 1'b0; exp_tmo = 1'b0; exp_sel = 0; exp_cu = 0;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        check_cycle(1'b0, 1'b0, 1'b0, "reset");
        reset = 1'b0;
        next_cycle();
        idle("post_reset", 2, 1'b0, 1'b1, 1'b0, 1'b0);

        // Nominal: done 3 cycles after each start
        set_all(3);
        run_frame("nominal", -1, -1, 1'b0);
        chk("nominal cycles_used", 32'(bus.cycles_used), 32);
        chk("nominal no_err", 32'(bus.err_timeout | bus.overrun), 0);

        // Fast engine
        set_all(1);
        run_frame("fast", -1, -1, 1'b0);
        chk("fast cycles_used", 32'(bus.cycles_used), 16);

        // Done exactly on the last allowed wait cycle is not a timeout
        set_all(TO);
        run_frame("edge64", -1, -1, 1'b0);
        chk("edge64 no_timeout", 32'(bus.err_timeout), 0);

        // Stalled engine
        set_all(0);
        run_frame("stall", -1, -1, 1'b0);
        chk("stall cycles_used", 32'(bus.cycles_used), 520);
        chk("stall err_timeout", 32'(bus.err_timeout), 1);
        idle("stall_clr", 1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("stall cleared", 32'(bus.err_timeout), 0);

        // Overrun mid-frame, then in the DONE cycle
        set_all(3);
        run_frame("ovr10", 10, -1, 1'b0);
        chk("ovr10 overrun", 32'(bus.overrun), 1);
        idle("ovr_clr", 1, 1'b0, 1'b1, 1'b0, 1'b1);
        run_frame("ovr_done", -2, -1, 1'b0);
        chk("ovr_done overrun", 32'(bus.overrun), 1);
        idle("ovr_clr2", 1, 1'b0, 1'b1, 1'b0, 1'b1);
        // Clear in the same cycle as a new overrun: error wins
        run_frame("ovr_vs_clr", 10, 10, 1'b0);
        chk("ovr_vs_clr overrun", 32'(bus.overrun), 1);
        idle("ovr_clr3", 1, 1'b0, 1'b1, 1'b0, 1'b1);

        // enable drops after the frame starts; frame still completes
        run_frame("en_drop", -1, -1, 1'b1);

        // Disabled rate and spurious done while idle
        idle("disabled", 4, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("spurious_done", 3, 1'b0, 1'b1, 1'b1, 1'b0);

        // Randomized frames
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < NV; i++)
                dly[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
            plan();
            ovr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, fd)) : -1;
            clr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, fd + 1)) : -1;
            run_frame("random", ovr, clr, 1'($urandom_range(0, 1)));
            idle("random_gap", int'($urandom_range(0, 2)), 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Reset in the middle of a frame
        set_all(3);
        for (int c = 0; c < 12; c++) begin
            bus.rate = (c == 0); bus.enable = 1'b1;
            bus.voice_done = (c == 4) || (c == 8);
            next_cycle();
        end
        bus.rate = 1'b0; bus.voice_done = 1'b0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        exp_ovr = 1'b0; exp_tmo = 1'b0; exp_sel = 0; exp_cu = 0;
        idle("after_reset", 3, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame("restart", -1, -1, 1'b0);
        chk("restart cycles_used", 32'(bus.cycles_used), 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
